// File: rtl/lcd_pkg.sv
// Shared LCD character-path definitions: control characters, line geometry and
// the character-port arbiter state encoding.
package lcd_pkg;

  localparam logic [7:0] NEWLINE        = 8'h0A;
  localparam logic [7:0] BACKSPACE      = 8'h08;
  localparam int         LCD_LINE_CHARS = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/lcd_release_tracker.sv
// Burst and idle counters for one grant; pulses release on newline, full line
// or idle timeout. Backpressure (stalled) never counts as idle.
module lcd_release_tracker
  import lcd_pkg::*;
#(
  parameter int MAX_BURST    = LCD_LINE_CHARS,
  parameter int IDLE_TIMEOUT = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       xfer,
  input  logic       valid,
  input  logic       stalled,
  input  logic [7:0] data,
  output logic       release_pulse
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);
  localparam logic [IW-1:0] IDLE_LIMIT  = IW'(IDLE_TIMEOUT);

  logic [BW-1:0] burst_cnt_q, burst_cnt_d, burst_next;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d, idle_next;
  logic          idle_cycle;

  always_comb begin
    burst_next    = burst_cnt_q + BW'(1);
    idle_next     = idle_cnt_q + IW'(1);
    idle_cycle    = !valid && !stalled;
    release_pulse = (xfer && (data == NEWLINE))
                  || (xfer && (burst_next == BURST_LIMIT))
                  || (idle_cycle && (idle_next == IDLE_LIMIT));

    burst_cnt_d = burst_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    if (clear || release_pulse) begin
      burst_cnt_d = '0;
      idle_cnt_d  = '0;
    end else if (xfer) begin
      if (burst_cnt_q != BURST_LIMIT) burst_cnt_d = burst_next;
      idle_cnt_d = '0;
    end else if (idle_cycle && (idle_cnt_q != IDLE_LIMIT)) begin
      idle_cnt_d = idle_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      burst_cnt_q <= '0;
      idle_cnt_q  <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

endmodule

// File: rtl/lcd_char_arbiter.sv
// Round-robin arbiter sharing the LCD FIFO write port between two character
// sources; a grant is held for a line-sized burst, data path is zero latency.
module lcd_char_arbiter
  import lcd_pkg::*;
#(
  parameter int MAX_BURST    = LCD_LINE_CHARS,
  parameter int IDLE_TIMEOUT = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       fifo_full,
  output logic       fifo_write,
  output logic [7:0] fifo_wdata,
  output logic [1:0] grant,
  output logic       busy
);

  arb_state_t state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       granted, sel_valid, xfer, stalled, release_pulse;
  logic [7:0] sel_data;

  // Output decode; ready and write are masked by reset combinationally.
  always_comb begin
    granted    = 1'b0;
    grant      = 2'b00;
    sel_valid  = 1'b0;
    sel_data   = 8'h00;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      ST_GRANT0: begin
        granted    = 1'b1;
        grant      = 2'b01;
        sel_valid  = req0_valid;
        sel_data   = req0_data;
        req0_ready = !fifo_full && !reset;
      end
      ST_GRANT1: begin
        granted    = 1'b1;
        grant      = 2'b10;
        sel_valid  = req1_valid;
        sel_data   = req1_data;
        req1_ready = !fifo_full && !reset;
      end
      default: ;
    endcase
    xfer       = sel_valid && !fifo_full && !reset;
    stalled    = sel_valid && fifo_full;
    fifo_write = xfer;
    fifo_wdata = xfer ? sel_data : wdata_q;
    busy       = granted;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wdata_d = xfer ? sel_data : wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_valid && (!req1_valid || !ptr_q)) state_d = ST_GRANT0;
        else if (req1_valid)                       state_d = ST_GRANT1;
      end
      ST_GRANT0, ST_GRANT1: begin
        if (release_pulse) begin
          state_d = ST_IDLE;
          ptr_d   = (state_q == ST_GRANT0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wdata_q <= wdata_d;
    end
  end

  lcd_release_tracker #(
    .MAX_BURST   (MAX_BURST),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) u_tracker (
    .clock        (clock),
    .reset        (reset),
    .clear        (!granted),
    .xfer         (xfer),
    .valid        (sel_valid),
    .stalled      (stalled),
    .data         (sel_data),
    .release_pulse(release_pulse)
  );

endmodule

// File: tb/tb_lcd_char_arbiter.sv
// Directed bench for lcd_char_arbiter: cycle table for basic grants plus
// sequences for burst limit, backpressure, idle timeout and mid-burst reset.
module tb_lcd_char_arbiter;
  import lcd_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       fifo_full, fifo_write, busy;
  logic [7:0] fifo_wdata;
  logic [1:0] grant;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  lcd_char_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .fifo_full (fifo_full),
    .fifo_write(fifo_write),
    .fifo_wdata(fifo_wdata),
    .grant     (grant),
    .busy      (busy)
  );

  typedef struct {
    logic       rst;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       full;
    logic       r0;
    logic       r1;
    logic       wr;
    logic [7:0] wd;
    logic [1:0] g;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic v0, input logic [7:0] d0,
                     input logic v1, input logic [7:0] d1, input logic full,
                     input logic r0, input logic r1, input logic wr,
                     input logic [7:0] wd, input logic [1:0] g);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.full = full;
    v.r0 = r0; v.r1 = r1; v.wr = wr; v.wd = wd; v.g = g;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    chk(name, {31'b0, got}, {31'b0, exp});
  endtask

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    chk(name, {24'b0, got}, {24'b0, exp});
  endtask

  task automatic drive(input logic rst, input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1, input logic full);
    reset = rst; req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1; fifo_full = full;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b [20];
    int         idx, bad, held;
    logic       exp_wr;

    drive(1, 0, 8'h00, 0, 8'h00, 0);
    tick(); tick();

    // rst v0 d0     v1 d1     full | r0 r1 wr wd     g
    add(1, 0, 8'h00, 0, 8'h00, 0,   0, 0, 0, 8'h00, 2'b00);
    add(0, 1, 8'h48, 0, 8'h00, 0,   0, 0, 0, 8'h00, 2'b00);
    add(0, 1, 8'h48, 0, 8'h00, 0,   1, 0, 1, 8'h48, 2'b01);
    add(0, 1, 8'h49, 0, 8'h00, 0,   1, 0, 1, 8'h49, 2'b01);
    add(0, 1, 8'h0A, 0, 8'h00, 0,   1, 0, 1, 8'h0A, 2'b01);
    add(0, 0, 8'h00, 0, 8'h00, 0,   0, 0, 0, 8'h0A, 2'b00);
    add(1, 0, 8'h00, 0, 8'h00, 0,   0, 0, 0, 8'h0A, 2'b00);
    add(0, 1, 8'h41, 1, 8'h61, 0,   0, 0, 0, 8'h00, 2'b00);
    add(0, 1, 8'h0A, 1, 8'h61, 0,   1, 0, 1, 8'h0A, 2'b01);
    add(0, 1, 8'h42, 1, 8'h61, 0,   0, 0, 0, 8'h0A, 2'b00);
    add(0, 1, 8'h42, 1, 8'h0A, 0,   0, 1, 1, 8'h0A, 2'b10);
    add(0, 1, 8'h43, 1, 8'h62, 0,   0, 0, 0, 8'h0A, 2'b00);
    add(0, 1, 8'h43, 1, 8'h62, 0,   1, 0, 1, 8'h43, 2'b01);
    add(0, 0, 8'h00, 1, 8'h62, 0,   1, 0, 0, 8'h43, 2'b01);
    add(0, 1, 8'h44, 1, 8'h62, 1,   0, 0, 0, 8'h43, 2'b01);
    add(0, 1, 8'h0A, 1, 8'h62, 0,   1, 0, 1, 8'h0A, 2'b01);
    add(0, 0, 8'h00, 0, 8'h00, 0,   0, 0, 0, 8'h0A, 2'b00);
    add(1, 1, 8'h55, 1, 8'h66, 0,   0, 0, 0, 8'h0A, 2'b00);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].v0, vq[i].d0, vq[i].v1, vq[i].d1, vq[i].full);
      @(negedge clock);
      chk1($sformatf("v%0d.req0_ready", i), req0_ready, vq[i].r0);
      chk1($sformatf("v%0d.req1_ready", i), req1_ready, vq[i].r1);
      chk1($sformatf("v%0d.fifo_write", i), fifo_write, vq[i].wr);
      chk8($sformatf("v%0d.fifo_wdata", i), fifo_wdata, vq[i].wd);
      chk($sformatf("v%0d.grant", i), {30'b0, grant}, {30'b0, vq[i].g});
      chk1($sformatf("v%0d.busy", i), busy, |vq[i].g);
      tick();
    end

    // req1 streams 20 bytes: 16 in the first grant, one bubble, then the rest.
    for (int i = 0; i < 20; i++) b[i] = 8'h30 + 8'(i);
    b[5] = BACKSPACE;
    drive(1, 0, 8'h00, 0, 8'h00, 0);
    tick();
    idx = 0;
    for (int cyc = 0; cyc < 22; cyc++) begin
      drive(0, 0, 8'h00, idx < 20, b[(idx < 20) ? idx : 0], 0);
      @(negedge clock);
      exp_wr = !(cyc == 0 || cyc == 17);
      chk($sformatf("burst.c%0d.grant", cyc), {30'b0, grant}, exp_wr ? 32'd2 : 32'd0);
      chk1($sformatf("burst.c%0d.fifo_write", cyc), fifo_write, exp_wr);
      if (exp_wr) begin
        chk8($sformatf("burst.c%0d.fifo_wdata", cyc), fifo_wdata, b[idx]);
        idx++;
      end
      tick();
    end

    // Backpressure for 2000 cycles must not time the grant out.
    drive(1, 0, 8'h00, 0, 8'h00, 0);
    tick();
    drive(0, 1, 8'h55, 0, 8'h00, 1);
    @(negedge clock);
    chk("full.arb_grant", {30'b0, grant}, 32'd0);
    tick();
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (fifo_write || req0_ready || grant != 2'b01) bad++;
      tick();
    end
    chk("full.stall_violations", bad, 0);
    drive(0, 1, 8'h55, 0, 8'h00, 0);
    @(negedge clock);
    chk1("full.resume_ready", req0_ready, 1'b1);
    chk1("full.resume_write", fifo_write, 1'b1);
    chk8("full.resume_wdata", fifo_wdata, 8'h55);
    tick();
    drive(0, 1, 8'h0A, 0, 8'h00, 0);
    @(negedge clock);
    chk1("full.newline_write", fifo_write, 1'b1);
    tick();
    drive(0, 0, 8'h00, 0, 8'h00, 0);
    @(negedge clock);
    chk("full.released", {30'b0, grant}, 32'd0);
    tick();

    // Idle timeout: grant held exactly 1000 cycles after last transfer.
    drive(1, 0, 8'h00, 0, 8'h00, 0);
    tick();
    drive(0, 1, 8'h41, 0, 8'h00, 0);
    tick();
    @(negedge clock);
    chk1("idle.xfer1", fifo_write, 1'b1);
    tick();
    drive(0, 1, 8'h42, 0, 8'h00, 0);
    @(negedge clock);
    chk1("idle.xfer2", fifo_write, 1'b1);
    tick();
    drive(0, 0, 8'h00, 0, 8'h00, 0);
    held = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clock);
      if (grant == 2'b00) break;
      held++;
      tick();
    end
    chk("idle.held_cycles", held, 1000);
    tick();
    drive(0, 1, 8'h43, 1, 8'h63, 0);
    @(negedge clock);
    chk("idle.bubble", {30'b0, grant}, 32'd0);
    tick();
    @(negedge clock);
    chk("idle.pointer_to_req1", {30'b0, grant}, 32'd2);
    tick();

    // Reset mid-burst after 5 bytes; the following burst counts from zero.
    drive(1, 0, 8'h00, 0, 8'h00, 0);
    tick();
    drive(0, 1, 8'h61, 0, 8'h00, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 8'h61 + 8'(k), 0, 8'h00, 0);
      @(negedge clock);
      chk1($sformatf("rst.pre%0d.write", k), fifo_write, 1'b1);
      tick();
    end
    drive(1, 1, 8'h66, 0, 8'h00, 0);
    @(negedge clock);
    chk1("rst.in_reset.write", fifo_write, 1'b0);
    chk1("rst.in_reset.ready", req0_ready, 1'b0);
    tick();
    drive(0, 0, 8'h00, 0, 8'h00, 0);
    @(negedge clock);
    chk("rst.after.grant", {30'b0, grant}, 32'd0);
    chk1("rst.after.busy", busy, 1'b0);
    tick();
    drive(0, 1, 8'h70, 0, 8'h00, 0);
    @(negedge clock);
    chk("rst.rearb.grant", {30'b0, grant}, 32'd0);
    tick();
    for (int k = 0; k < 16; k++) begin
      drive(0, 1, 8'h70 + 8'(k), 0, 8'h00, 0);
      @(negedge clock);
      chk($sformatf("rst.burst%0d.grant", k), {30'b0, grant}, 32'd1);
      chk1($sformatf("rst.burst%0d.write", k), fifo_write, 1'b1);
      tick();
    end
    @(negedge clock);
    chk("rst.burst_end.grant", {30'b0, grant}, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_char_arbiter.md
Name: lcd_char_arbiter

Overview:
Shares the single LCD character FIFO write port between two character sources, for example a UART receiver and a keypad decoder. It grants the port to one requester at a time and holds the grant for a line-sized burst, so that characters from the two sources are not interleaved mid-line. Grants alternate round-robin between the sources. It sits upstream of the LCD controller's input FIFO and drives that FIFO's write side.

Parameters:
MAX_BURST, 16, maximum characters per grant (one LCD line)
IDLE_TIMEOUT, 1000, cycles a granted requester may sit with valid low before its grant is revoked

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has a character
req0_data  input  8  requester 0 character
req0_ready  output  1  requester 0 character accepted this cycle when valid & ready
req1_valid  input  1  requester 1 has a character
req1_data  input  8  requester 1 character
req1_ready  output  1  requester 1 character accepted this cycle when valid & ready
fifo_full  input  1  LCD FIFO full
fifo_write  output  1  write strobe to LCD FIFO
fifo_wdata  output  8  character to LCD FIFO
grant  output  2  one-hot current owner; 00 when idle
busy  output  1  a grant is held

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset values:
  - state IDLE; grant=00; busy=0; req0_ready=req1_ready=0.
  - fifo_write=0, fifo_wdata=0x00; priority pointer=0 (requester 0 preferred); burst_cnt=0; idle_cnt=0.
- Reset mid-burst:
  - The burst is abandoned.
  - fifo_write and both ready outputs are forced to 0 combinationally for the whole time reset is high.
- States: IDLE, GRANT0, GRANT1.
- IDLE:
  - Only one requester valid: grant it.
  - Both valid: grant the requester named by the priority pointer.
  - The grant becomes visible on the next cycle (1-cycle arbitration latency). No transfers happen in IDLE.
- GRANTn:
  - reqn_ready = !fifo_full. The other requester's ready = 0.
  - fifo_write = reqn_valid & !fifo_full, combinational pass-through, with fifo_wdata = reqn_data in the same cycle (zero latency).
  - fifo_wdata holds its last written value when no write occurs.
- Transfer (reqn_valid & reqn_ready): burst_cnt += 1 and idle_cnt cleared.
- idle_cnt:
  - Increments only in cycles with reqn_valid=0.
  - Holds while the requester is stalled by fifo_full (backpressure never counts as idle).
- Release conditions, evaluated on the cycle of the transfer or count:
  - a transferred byte equals NEWLINE (0x0A);
  - burst_cnt reaches MAX_BURST after a transfer;
  - idle_cnt reaches IDLE_TIMEOUT.
- Release actions:
  - Next state IDLE; burst_cnt=0, idle_cnt=0.
  - Priority pointer set to the other requester, so there is 1 bubble cycle between grants.
- Simultaneous release conditions (e.g. a newline that is also the 16th character) cause a single release. No double pointer toggle.
- The released requester's valid may stay high. It is re-granted only if the other requester is not valid in IDLE.
- BACKSPACE (0x08) and all other bytes are forwarded unmodified. They do not affect arbitration except by counting toward burst_cnt.
- Counter widths: burst_cnt is $clog2(MAX_BURST+1) bits; idle_cnt is $clog2(IDLE_TIMEOUT+1) bits. Neither wraps; both are cleared on release.
- Illegal state encoding: returns to IDLE on the next clock.

Decomposition:
- Shared package lcd_pkg:
  - character constants NEWLINE=8'h0A, BACKSPACE=8'h08;
  - arbiter state encoding (IDLE=0, GRANT0=1, GRANT1=2);
  - LCD geometry constant LCD_LINE_CHARS=16, which is the default source for MAX_BURST.
- One natural sub-module, lcd_release_tracker:
  - contains burst_cnt and idle_cnt;
  - inputs: xfer, valid, stalled, data, clear;
  - output: a single release pulse;
  - lets release logic be tested apart from the FSM.

Test Plan:
1. Reset then req0 sends "HI\n" (0x48,0x49,0x0A) with fifo_full=0 -> grant=01 on the cycle after first valid; 3 fifo_write pulses with those bytes in order; grant=00 the cycle after 0x0A.
2. req0 and req1 both valid from reset -> requester 0 granted first. After its newline, requester 1 is granted following 1 idle cycle. Next simultaneous request goes to requester 0.
3. req1 streams 20 non-newline bytes -> exactly 16 written under GRANT1, then release. Bytes 17-20 are accepted only after re-grant (or after req0 is served if req0 is valid).
4. fifo_full=1 for 2000 cycles during GRANT0 with req0_valid=1 -> no writes, req0_ready=0, grant held (no timeout). After full drops, writes resume.
5. GRANT0, req0 sends 2 bytes then drops valid -> grant released exactly 1000 cycles after the last transfer; pointer moves to requester 1.
6. Assert reset for 1 cycle mid-burst (after 5 bytes) -> fifo_write=0 in the reset cycle; state IDLE and grant=00 after it; the next burst counts from 0.
